// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first,
// with start/busy/done handshake and operand validity flagging.

module bcd_digit_add (
   input  logic [3:0] x_i,
   input  logic [3:0] y_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic [4:0] raw;

   always_comb begin
      raw = {1'b0, x_i} + {1'b0, y_i} + {4'd0, c_i};
      s_o = raw[3:0];
      c_o = 1'b0;
      if (raw > 5'd9) begin
         s_o = raw[3:0] + 4'd6;
         c_o = 1'b1;
      end
   end
endmodule

module bcd_serial_addsub #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sub,
   input  logic                  ci,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic [4*DIGITS-1:0]   result,
   output logic                  cout,
   output logic                  invalid,
   output logic                  busy,
   output logic                  done
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                 state_q;
   logic [DIGITS-1:0][3:0] a_v, b_v, b_nc;
   logic [DIGITS-1:0][3:0] a_q, bp_q, res_q;
   logic [DIGITS-1:0]      bad;
   logic [IW-1:0]          idx_q;
   logic                   carry_q, sub_q;
   logic                   cout_q, inv_q, busy_q, done_q;
   logic [3:0]             dig_d;
   logic                   carry_d;

   assign a_v = a;
   assign b_v = b;

   // Subtraction is a + (nines complement of b) + ~borrow_in, so the same
   // digit adder serves both modes.
   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      assign b_nc[g] = 4'd9 - b_v[g];
      assign bad[g]  = (a_v[g] > 4'd9) | (b_v[g] > 4'd9);
   end

   bcd_digit_add u_add (
      .x_i (a_q[idx_q]),
      .y_i (bp_q[idx_q]),
      .c_i (carry_q),
      .s_o (dig_d),
      .c_o (carry_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         bp_q    <= '0;
         res_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         cout_q  <= 1'b0;
         inv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= S_RUN;
                  a_q     <= a_v;
                  bp_q    <= sub ? b_nc : b_v;
                  sub_q   <= sub;
                  carry_q <= sub ? ~ci : ci;
                  idx_q   <= '0;
                  res_q   <= '0;
                  cout_q  <= 1'b0;
                  inv_q   <= |bad;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               res_q[idx_q] <= dig_d;
               carry_q      <= carry_d;
               idx_q        <= idx_q + 1'b1;
               if (idx_q == LAST) begin
                  state_q <= S_DONE;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  // Invalid operands yield a clean zero rather than garbage digits.
                  if (inv_q) begin
                     res_q  <= '0;
                     cout_q <= 1'b0;
                  end else begin
                     cout_q <= sub_q ? ~carry_d : carry_d;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign result  = res_q;
   assign cout    = cout_q;
   assign invalid = inv_q;
   assign busy    = busy_q;
   assign done    = done_q;
endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised multi-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first.
- Successor to the 4-bit single-digit BCD adder: adds configurable width, a subtract mode, borrow/carry chaining, input validity checking and a start/busy/done handshake.
- Sits between operand registers (switch/keypad capture) and the 7-segment display driver in lab datapaths.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin operation; sampled only in IDLE.
sub  input  1  0 = add, 1 = subtract (a - b).
ci  input  1  carry-in (add) or borrow-in (subtract).
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
b  input  4*DIGITS  operand B, packed BCD.
result  output  4*DIGITS  packed BCD result; held until the next accepted start.
cout  output  1  add: decimal carry-out; sub: borrow-out (1 when a < b + ci).
invalid  output  1  1 when any latched digit of a or b was greater than 9.
busy  output  1  high while the operation is in progress.
done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (rst_n low, asynchronous): the FSM goes to IDLE. result, cout, invalid, busy, done, the digit index, the carry and the operand latches all clear to 0. Deassertion takes effect at the next clk edge.
- FSM states:
  - IDLE: start=1 -> RUN.
  - RUN: after DIGITS digit cycles -> DONE.
  - DONE: unconditionally -> IDLE.
- On accepting start (rising edge in IDLE, call it T0):
  - Latch a, sub and ci.
  - Latch b' = b for add, or b' = nine's complement of each digit (9 - b_d) for subtract.
  - Set the carry register to ci for add, or to ~ci for subtract.
  - Set the digit index to 0 and clear result.
  - Set invalid = OR over all digits of (a_d > 9) | (b_d > 9).
- RUN, one digit per edge:
  - s = a_d + b'_d + carry, computed at 5 bits (range 0..19 for valid inputs).
  - If s > 9: digit = (s + 6)[3:0] and carry = 1. Otherwise digit = s[3:0] and carry = 0.
  - Write the digit to result[4*idx+3 : 4*idx], then increment idx.
- Latency and handshake:
  - busy rises after T0 and stays high for DIGITS cycles, through the last digit edge T0+DIGITS.
  - At T0+DIGITS the FSM enters DONE: busy=0, done=1 for exactly one cycle, and result, cout and invalid are valid.
- Output qualification:
  - Add: cout = final carry.
  - Sub: cout = ~final carry (borrow). On borrow, result is the ten's complement wrap, (a - b - ci) mod 10^DIGITS.
  - If invalid=1: result is forced to 0 and cout to 0 at DONE. Timing is unchanged and done still pulses.
- Operand and start rules:
  - start while busy or in DONE is ignored.
  - Changes on a, b, sub or ci after T0 have no effect on the operation in progress.
  - start held high continuously starts a new operation on the first IDLE cycle after DONE, giving a throughput of one result per DIGITS+2 cycles.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and all outputs read 0.
- DIGITS=1: busy is high for 1 cycle, then done pulses; behaviour is otherwise identical to the single-digit adder with a handshake.

Test Plan:
- DIGITS=4, add a=1234, b=5678, ci=0 -> result=6912, cout=0, invalid=0; busy high for 4 cycles; done pulses exactly once, 4 edges after the start edge.
- Add a=9999, b=0001, ci=0 -> result=0000, cout=1. Add a=0999, b=0000, ci=1 -> result=1000, cout=0.
- Subtract a=0500, b=0123, ci=0 -> result=0377, cout=0. Subtract a=0123, b=0500, ci=0 -> result=9623, cout=1. Subtract a=0000, b=0000, ci=1 -> result=9999, cout=1.
- Invalid operand a=0x12A4, b=0001 -> invalid=1, result=0000, cout=0, done still pulses after 4 cycles.
- Pulse start again 2 cycles into an operation, and change a and b during RUN -> no effect on the current result; the second start is not queued.
- Drive rst_n low during RUN cycle 2 -> all outputs read 0 immediately (asynchronous), no done pulse. After release, a new start of 4321+1111 gives 5432.
